// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C master bit-level engines
// (i2c_master_write_bit and the bit reader).
//   I2C_QUARTER_CYCLES : default clock cycles per quarter SCL period
//                        (125 at 50 MHz gives a 100 kHz SCL)
//   bit_state_e        : bit-FSM state encoding. The 3-bit values are fixed
//                        and must match the reader, which uses the same encoding.
package i2c_pkg;

  localparam int unsigned I2C_QUARTER_CYCLES = 125;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_HIGH_A = 3'd2,
    ST_HIGH_B = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } bit_state_e;

  // True for the four states that each last one quarter SCL period.
  function automatic logic is_timed(input bit_state_e s);
    return (s == ST_SETUP) || (s == ST_HIGH_A) || (s == ST_HIGH_B) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// i2c_quarter_timer: quarter-SCL-period counter shared by the bit engines.
//   clock  in  system clock
//   reset  in  asynchronous, active-high reset
//   load   in  restart the count from zero
//   enable in  count this cycle
//   hold   in  keep the count at zero (SCL stretched by a slave)
//   done   out high during the last cycle of the quarter period
//              (enable=1, hold=0, count=QUARTER_CYCLES-1)
// The count returns to zero on the cycle done is high, so every quarter
// lasts exactly QUARTER_CYCLES enabled, unheld cycles.
module i2c_quarter_timer
  import i2c_pkg::*;
#(
  parameter int unsigned QUARTER_CYCLES = I2C_QUARTER_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  input  logic hold,
  output logic done
);

  localparam int unsigned CW = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(QUARTER_CYCLES - 1);

  logic [CW-1:0] count;

  assign done = enable && !hold && (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load || hold || done) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_write_bit.sv
// i2c_master_write_bit: sends one data bit on SDA and produces one full SCL
// pulse. It checks SDA readback at mid-high (arbitration loss or bus fault)
// and waits while a slave stretches SCL. It shares the go/finish handshake
// with the bit reader under the byte-level controller.
//   clock   in  system clock
//   reset   in  asynchronous, active-high reset
//   go      in  request to send a bit (level; only sampled in IDLE)
//   data    in  bit to send, latched when go is accepted
//   finish  out bit complete; stays high in DONE until go drops
//   error   out readback differed from the sent bit; valid while finish=1
//   scl_out out SCL drive (0 = pull low, 1 = release)
//   scl_in  in  SCL bus level
//   sda_out out SDA drive (0 = pull low, 1 = release)
//   sda_in  in  SDA bus level
// Line timing per bit: SCL low 1 quarter, high 2 quarters (plus any stretch),
// then low 1 quarter. After the bit, SCL stays low and SDA keeps the bit.
module i2c_master_write_bit
  import i2c_pkg::*;
#(
  parameter int unsigned QUARTER_CYCLES = I2C_QUARTER_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic go,
  input  logic data,
  output logic finish,
  output logic error,
  output logic scl_out,
  input  logic scl_in,
  output logic sda_out,
  input  logic sda_in
);

  bit_state_e state;
  logic       bit_q;
  logic       accept;
  logic       timer_en;
  logic       timer_hold;
  logic       q_done;

  always_comb begin
    accept     = (state == ST_IDLE) && go;
    timer_en   = is_timed(state);
    // The high phase does not start counting until the bus actually shows SCL high.
    timer_hold = (state == ST_HIGH_A) && !scl_in;
  end

  i2c_quarter_timer #(
    .QUARTER_CYCLES(QUARTER_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (accept),
    .enable (timer_en),
    .hold   (timer_hold),
    .done   (q_done)
  );

  // Line levels are registered and change only on transitions, so IDLE and
  // DONE hold whatever the previous phase drove.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_q   <= 1'b1;
      scl_out <= 1'b1;
      sda_out <= 1'b1;
      finish  <= 1'b0;
      error   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            bit_q   <= data;
            error   <= 1'b0;
            scl_out <= 1'b0;
            sda_out <= data;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (q_done) begin
            scl_out <= 1'b1;
            state   <= ST_HIGH_A;
          end
        end
        ST_HIGH_A: begin
          if (q_done) begin
            error <= (sda_in != bit_q);
            state <= ST_HIGH_B;
          end
        end
        ST_HIGH_B: begin
          if (q_done) begin
            scl_out <= 1'b0;
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (q_done) begin
            finish <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!go) begin
            finish <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
